snow64_mem_bus_arbiter: RTL and testbench
=========================================

Name: snow64_mem_bus_arbiter

Overview:
- Shares the single external memory port between two requesters: instruction cache line fills (read-only) and LAR-file/data-cache line transfers (read or write).
- Serves one transaction at a time. Requests are latched at grant.
- Round-robin arbitration applies when both requesters are pending, so neither the IF/ID fetch path nor the load/store wait path can starve the other.

Parameters:
- WIDTH_ADDR, 64, byte address width (matches CPU address width).
- WIDTH_DATA, 256, memory line width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- instr_req  in  1  instr cache requests a line read; held until instr_done.
- instr_addr  in  WIDTH_ADDR  line address for instr read.
- instr_done  out  1  one-cycle pulse: instr transaction complete, instr_rdata valid.
- instr_rdata  out  WIDTH_DATA  returned line for instr requester.
- data_req  in  1  data requester pending; held until data_done.
- data_addr  in  WIDTH_ADDR  line address.
- data_we  in  1  1 = write, 0 = read.
- data_wdata  in  WIDTH_DATA  write line.
- data_done  out  1  one-cycle pulse: data transaction complete.
- data_rdata  out  WIDTH_DATA  returned line; all zero after a write.
- mem_req  out  1  request to memory; held until mem_ack.
- mem_addr  out  WIDTH_ADDR  latched address.
- mem_we  out  1  latched write flag; always 0 for instr transactions.
- mem_wdata  out  WIDTH_DATA  latched write data; 0 for instr transactions.
- mem_ack  in  1  memory accepted the request this cycle.
- mem_valid  in  1  memory response/completion this cycle.
- mem_rdata  in  WIDTH_DATA  read data, qualified by mem_valid.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Every output is 0.
  - last_owner is set to INSTR, so data wins the first tie.
  - Reset mid-transaction abandons it with no done pulse. Any later mem_valid is ignored while in IDLE.
- States: IDLE, ISSUE, WAIT, RESP, HOLD. All outputs are registered.
- IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one that is not last_owner.
  - On grant: latch addr, we and wdata into the mem_* registers (instr forces we = 0, wdata = 0); set owner and last_owner to the granted requester; go to ISSUE.
  - No request: stay in IDLE with mem_req = 0.
- ISSUE:
  - mem_req = 1. mem_addr, mem_we and mem_wdata are stable until the transaction ends.
  - On mem_ack: drop mem_req next cycle and go to WAIT.
  - If mem_valid arrives in the same cycle as mem_ack: go directly to RESP and capture mem_rdata.
  - mem_valid without mem_ack: ignored.
- WAIT:
  - mem_req = 0.
  - On mem_valid: capture mem_rdata into the owner's rdata register (0 if mem_we) and go to RESP.
- RESP:
  - The owner's done = 1 for exactly one cycle. The owner's rdata holds until that owner's next done.
  - Go to HOLD.
- HOLD:
  - One idle cycle. The requester must have deasserted req by the end of this cycle.
  - Requests are not sampled. Go to IDLE.
- The non-owner may assert or hold req at any time. It is granted in the next IDLE.
- Latency with a zero-wait memory (ack and valid in the same ISSUE cycle): req sampled at edge 0, mem_req high in cycle 1, done high in cycle 2, next grant at edge 4. Back-to-back throughput: one transaction per 4 cycles minimum.
- Changes to addr, we or wdata after grant have no effect.
- mem_ack outside ISSUE is ignored. mem_valid outside ISSUE/WAIT is ignored.

Test Plan:
- Reset then idle: rst high 2 cycles, no reqs → all outputs 0. Stray mem_valid=1 with mem_rdata=all-ones → no done pulse, rdata stays 0.
- Single instr read: instr_req with addr 0x1000, mem acks 1 cycle later and gives mem_valid with rdata 0xAB..AB 3 cycles after that → mem_addr=0x1000 and mem_we=0 throughout ISSUE; instr_done pulses once; instr_rdata=0xAB..AB; data_done stays 0.
- Simultaneous requests after reset: instr (0x2000) and data write (0x3000, wdata 0x55..55) asserted together → data granted first with mem_we=1 and mem_wdata=0x55..55, data_rdata=0. instr is served next at 0x2000.
- Fairness: both reqs held continuously, reasserted after each done → grant order alternates D, I, D, I over 4 transactions.
- Zero-wait memory: mem_ack and mem_valid both high in the first ISSUE cycle → done exactly 2 cycles after req is sampled; next grant 4 cycles after the first.
- Reset mid-WAIT: data read outstanding, rst pulsed 1 cycle, then mem_valid → no data_done, outputs 0, arbiter back in IDLE and grants a new instr_req normally.

Source files
------------

// File: rtl/snow64_mem_bus_arbiter.sv
// Shares the single external memory port between the instruction-cache line
// filler and the LAR-file/data-cache transfer path, one transaction at a time.
module snow64_mem_bus_arbiter #(
    parameter int WIDTH_ADDR = 64,
    parameter int WIDTH_DATA = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  instr_req,
    input  logic [WIDTH_ADDR-1:0] instr_addr,
    output logic                  instr_done,
    output logic [WIDTH_DATA-1:0] instr_rdata,

    input  logic                  data_req,
    input  logic [WIDTH_ADDR-1:0] data_addr,
    input  logic                  data_we,
    input  logic [WIDTH_DATA-1:0] data_wdata,
    output logic                  data_done,
    output logic [WIDTH_DATA-1:0] data_rdata,

    output logic                  mem_req,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic                  mem_we,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_valid,
    input  logic [WIDTH_DATA-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_t;

    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  mem_req_q, mem_req_d;
    logic [WIDTH_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [WIDTH_DATA-1:0] mem_wdata_q, mem_wdata_d;
    logic                  instr_done_q, instr_done_d;
    logic                  data_done_q, data_done_d;
    logic [WIDTH_DATA-1:0] instr_rdata_q, instr_rdata_d;
    logic [WIDTH_DATA-1:0] data_rdata_q, data_rdata_d;

    logic                  grant_data;
    logic                  resp_fire;
    logic [WIDTH_DATA-1:0] rdata_cap;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = mem_we_q;
        mem_wdata_d   = mem_wdata_q;
        instr_done_d  = 1'b0;
        data_done_d   = 1'b0;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        grant_data    = 1'b0;
        resp_fire     = 1'b0;
        rdata_cap     = '0;

        case (state_q)
            ST_IDLE: begin
                if (instr_req || data_req) begin
                    // On a tie the requester that did not own the bus last wins.
                    grant_data   = data_req && (!instr_req || (last_owner_q == OWN_INSTR));
                    owner_d      = grant_data ? OWN_DATA : OWN_INSTR;
                    last_owner_d = grant_data ? OWN_DATA : OWN_INSTR;
                    mem_addr_d   = grant_data ? data_addr : instr_addr;
                    mem_we_d     = grant_data ? data_we : 1'b0;
                    mem_wdata_d  = grant_data ? data_wdata : '0;
                    mem_req_d    = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT;
                    resp_fire = mem_valid;
                end
            end
            ST_WAIT: begin
                resp_fire = mem_valid;
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (resp_fire) begin
            rdata_cap = mem_we_q ? '0 : mem_rdata;
            state_d   = ST_RESP;
            if (owner_q == OWN_DATA) begin
                data_rdata_d = rdata_cap;
                data_done_d  = 1'b1;
            end else begin
                instr_rdata_d = rdata_cap;
                instr_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_INSTR;
            last_owner_q  <= OWN_INSTR;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            instr_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_done_q  <= instr_done_d;
            data_done_q   <= data_done_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign instr_done  = instr_done_q;
    assign data_done   = data_done_q;
    assign instr_rdata = instr_rdata_q;
    assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_snow64_mem_bus_arbiter.sv
// Bench for snow64_mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin / memory-response model.
module tb_snow64_mem_bus_arbiter;

    localparam int AW = 64;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_done;
    logic [DW-1:0] instr_rdata;
    logic          data_req;
    logic [AW-1:0] data_addr;
    logic          data_we;
    logic [DW-1:0] data_wdata;
    logic          data_done;
    logic [DW-1:0] data_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata;

    snow64_mem_bus_arbiter #(.WIDTH_ADDR(AW), .WIDTH_DATA(DW)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_done(instr_done), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: last bus owner (1 = data) and each requester's last returned line.
    bit            model_last;
    logic [DW-1:0] exp_irdata;
    logic [DW-1:0] exp_drdata;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom & 32'hFFFF_FFE0};
    endfunction

    task automatic check_outputs_zero();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_instr_done", instr_done, 0);
        check_eq("rst_data_done", data_done, 0);
        check_eq("rst_instr_rdata", instr_rdata, 0);
        check_eq("rst_data_rdata", data_rdata, 0);
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        rst = 1'b1;
        instr_req = 1'b0; data_req = 1'b0;
        mem_ack = 1'b0; mem_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b0;
        exp_irdata = '0;
        exp_drdata = '0;
    endtask

    task automatic set_instr(input logic [AW-1:0] a);
        instr_req = 1'b1; instr_addr = a;
    endtask

    task automatic set_data(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        data_req = 1'b1; data_addr = a; data_we = we; data_wdata = wd;
    endtask

    task automatic check_issue(input logic [AW-1:0] ea, input logic ew, input logic [DW-1:0] ewd);
        check_eq("issue_mem_req", mem_req, 1);
        check_eq("issue_mem_addr", mem_addr, ea);
        check_eq("issue_mem_we", mem_we, ew);
        check_eq("issue_mem_wdata", mem_wdata, ewd);
    endtask

    // Serve one transaction: called at a negedge while the arbiter is idle with
    // the upcoming grant's requests already driven.
    task automatic serve_one(input int ack_dly, input int val_dly, input bit stray,
                             input logic [DW-1:0] rd, output bit owner,
                             output int g_cyc, output int d_cyc);
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ewd;
        bit            seen;
        seen  = 1'b0;
        owner = (instr_req && data_req) ? !model_last : data_req;
        ea    = owner ? data_addr : instr_addr;
        ew    = owner ? data_we : 1'b0;
        ewd   = owner ? data_wdata : '0;
        model_last = owner;
        g_cyc = 0;
        d_cyc = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        g_cyc = cyc;
        check_eq("grant_seen", seen, 1);
        if (!seen) return;
        // Owner changes its inputs after grant; the latched transaction must not move.
        if (owner) begin
            data_addr = rand_addr(); data_wdata = rand256(); data_we = !data_we;
        end else begin
            instr_addr = rand_addr();
        end
        for (int i = 0; i < ack_dly; i++) begin
            check_issue(ea, ew, ewd);
            mem_valid = stray;
            mem_rdata = ~rd;
            @(negedge clk);
            mem_valid = 1'b0;
            check_eq("issue_no_instr_done", instr_done, 0);
            check_eq("issue_no_data_done", data_done, 0);
        end
        check_issue(ea, ew, ewd);
        mem_ack = 1'b1;
        if (val_dly == 0) begin
            mem_valid = 1'b1; mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = rand256();
        if (val_dly > 0) begin
            for (int i = 1; i < val_dly; i++) begin
                check_eq("wait_mem_req_low", mem_req, 0);
                check_eq("wait_no_done", instr_done | data_done, 0);
                mem_ack = stray;
                @(negedge clk);
                mem_ack = 1'b0;
            end
            check_eq("wait_mem_req_low", mem_req, 0);
            check_eq("wait_no_done", instr_done | data_done, 0);
            mem_valid = 1'b1; mem_rdata = rd;
            @(negedge clk);
            mem_valid = 1'b0; mem_rdata = rand256();
        end
        d_cyc = cyc;
        if (owner) exp_drdata = ew ? '0 : rd;
        else       exp_irdata = rd;
        check_eq("resp_instr_done", instr_done, !owner);
        check_eq("resp_data_done", data_done, owner);
        check_eq("resp_instr_rdata", instr_rdata, exp_irdata);
        check_eq("resp_data_rdata", data_rdata, exp_drdata);
        check_eq("resp_mem_req", mem_req, 0);
        if (owner) data_req = 1'b0;
        else       instr_req = 1'b0;
        @(negedge clk);
        check_eq("hold_done_low", instr_done | data_done, 0);
        check_eq("hold_instr_rdata", instr_rdata, exp_irdata);
        check_eq("hold_data_rdata", data_rdata, exp_drdata);
        @(negedge clk);
    endtask

    initial begin
        bit  own;
        int  g1, g2, d1, c0;
        bit  seen;

        rst = 1'b1;
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_wdata = '0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = '0;

        // Reset then idle, with a stray response that must be ignored.
        reset_dut(2);
        check_outputs_zero();
        mem_valid = 1'b1; mem_rdata = '1;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        check_eq("stray_valid_instr_done", instr_done, 0);
        check_eq("stray_valid_data_done", data_done, 0);
        check_eq("stray_valid_instr_rdata", instr_rdata, 0);
        check_eq("stray_valid_data_rdata", data_rdata, 0);

        // Single instruction read with a slow memory.
        set_instr(64'h1000);
        serve_one(1, 3, 1'b0, {32{8'hAB}}, own, g1, d1);
        check_eq("single_owner_instr", own, 0);
        check_eq("single_instr_rdata", instr_rdata, {32{8'hAB}});

        // Simultaneous requests after reset: data wins the first tie.
        reset_dut(1);
        set_instr(64'h2000);
        set_data(64'h3000, 1'b1, {32{8'h55}});
        serve_one(0, 2, 1'b0, rand256(), own, g1, d1);
        check_eq("tie_first_data", own, 1);
        check_eq("tie_write_rdata_zero", data_rdata, 0);
        serve_one(1, 1, 1'b0, rand256(), own, g1, d1);
        check_eq("tie_second_instr", own, 0);

        // Fairness with both requesters continuously pending.
        reset_dut(1);
        for (int k = 0; k < 4; k++) begin
            if (!instr_req) set_instr(rand_addr());
            if (!data_req) set_data(rand_addr(), 1'($urandom), rand256());
            serve_one(0, 1, 1'b0, rand256(), own, g1, d1);
            check_eq("fair_order", own, (k % 2 == 0) ? 1 : 0);
        end

        // Zero-wait memory latency and back-to-back throughput.
        reset_dut(1);
        set_instr(64'h5000);
        set_data(64'h6000, 1'b0, '0);
        c0 = cyc;
        serve_one(0, 0, 1'b0, rand256(), own, g1, d1);
        check_eq("zw_done_latency", d1 - c0, 2);
        serve_one(0, 0, 1'b0, rand256(), own, g2, d1);
        check_eq("zw_grant_spacing", g2 - g1, 4);

        // Reset while a data read is waiting for its response.
        reset_dut(1);
        set_data(64'h7000, 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        check_eq("midwait_grant_seen", seen, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        data_req = 1'b0;
        mem_valid = 1'b1; mem_rdata = '1;
        @(negedge clk);
        mem_valid = 1'b0;
        check_outputs_zero();
        @(negedge clk);
        check_eq("midwait_no_data_done", data_done, 0);
        model_last = 1'b0;
        exp_irdata = '0; exp_drdata = '0;
        set_instr(64'h4000);
        serve_one(1, 1, 1'b1, rand256(), own, g1, d1);
        check_eq("midwait_regrant_instr", own, 0);

        // Randomized traffic against the model.
        reset_dut(1);
        for (int k = 0; k < 40; k++) begin
            if (!instr_req && ($urandom_range(0, 1) == 1)) set_instr(rand_addr());
            if (!data_req && ($urandom_range(0, 1) == 1))
                set_data(rand_addr(), 1'($urandom), rand256());
            if (!instr_req && !data_req) begin
                if ($urandom_range(0, 1) == 1) set_instr(rand_addr());
                else set_data(rand_addr(), 1'($urandom), rand256());
            end
            serve_one($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                      rand256(), own, g1, d1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
